lut_func_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's fixed two-function logic selector.
- Evaluates three programmable truth tables per operand:
  - W over x.
  - F over {W, x[N_IN-2:0]}.
  - G over x.
- Output O = S ? G : F.
- Valid/ready streaming with backpressure; tables are rewritable at run time through a config port. Sits between operand source and result sink in the logic-evaluation datapath.

---
 rtl/lut_func_pipe_if.sv | 45 ++++
 rtl/lut_func_pipe.sv | 135 +++++++++++++
 tb/tb_lut_func_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_func_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_func_pipe_if
// Purpose  : Operand/result stream and table-config bundle for lut_func_pipe.
//            cfg_rdata exists only when LUT_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_func_pipe_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_x;
    logic            in_s;
    logic            out_valid;
    logic            out_ready;
    logic            out_o;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [N_IN-1:0] cfg_addr;
    logic            cfg_data;
    logic            cfg_busy;
`ifdef LUT_READBACK_EN
    logic            cfg_rdata;
`endif

    modport master (
        output in_valid, in_x, in_s, out_ready,
        output cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_o, cfg_busy
`ifdef LUT_READBACK_EN
        , input cfg_rdata
`endif
    );

    modport slave (
        input  in_valid, in_x, in_s, out_ready,
        input  cfg_we, cfg_sel, cfg_addr, cfg_data,
        output in_ready, out_valid, out_o, cfg_busy
`ifdef LUT_READBACK_EN
        , output cfg_rdata
`endif
    );
endinterface
`default_nettype wire

// File: rtl/lut_func_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lut_func_pipe
// Purpose  : Three-stage pipelined evaluator of programmable truth tables,
//            O = S ? G[x] : F[{W[x], x[N_IN-2:0]}]. Optional table readback
//            port is enabled by defining LUT_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lut_func_pipe #(
    parameter int N_IN   = 4,
    parameter     W_INIT = 16'h47E7,
    parameter     F_INIT = 16'h6F44,
    parameter     G_INIT = 16'h2CE9
) (
    input  logic               clk,
    input  logic               rst,
    lut_func_pipe_if.slave     bus
);
    localparam int                 c_DEPTH  = 2 ** N_IN;
    localparam logic [c_DEPTH-1:0] c_W_INIT = c_DEPTH'(W_INIT);
    localparam logic [c_DEPTH-1:0] c_F_INIT = c_DEPTH'(F_INIT);
    localparam logic [c_DEPTH-1:0] c_G_INIT = c_DEPTH'(G_INIT);

    logic [c_DEPTH-1:0] r_tab_w;
    logic [c_DEPTH-1:0] r_tab_f;
    logic [c_DEPTH-1:0] r_tab_g;

    logic               r_v1, r_v2, r_v3;
    logic [N_IN-1:0]    r_x1;
    logic               r_s1, r_w1;
    logic               r_s2, r_f2, r_g2;
    logic               r_o3;

    logic               w_stall;
    logic               w_busy;
    logic               w_cfg_accept;
    logic               w_in_ready;
    logic               w_accept;
    logic [N_IN-1:0]    w_f_idx;

    assign w_stall      = r_v3 & ~bus.out_ready;
    assign w_busy       = r_v1 | r_v2 | r_v3;
    // Writes only land on an empty pipeline, so no item ever sees a half-updated table.
    assign w_cfg_accept = bus.cfg_we & ~w_busy & (bus.cfg_sel != 2'd3);
    assign w_in_ready   = ~w_stall & ~w_cfg_accept;
    assign w_accept     = bus.in_valid & w_in_ready;

    generate
        if (N_IN == 1) begin : g_fidx_w_only
            assign w_f_idx = r_w1;
        end else begin : g_fidx_cat
            assign w_f_idx = {r_w1, r_x1[N_IN-2:0]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tab_w <= c_W_INIT;
            r_tab_f <= c_F_INIT;
            r_tab_g <= c_G_INIT;
        end else if (w_cfg_accept) begin
            case (bus.cfg_sel)
                2'd0:    r_tab_w[bus.cfg_addr] <= bus.cfg_data;
                2'd1:    r_tab_f[bus.cfg_addr] <= bus.cfg_data;
                2'd2:    r_tab_g[bus.cfg_addr] <= bus.cfg_data;
                default: ;
            endcase
        end
    end

    // A stall freezes every stage, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_x1 <= '0;
            r_s1 <= 1'b0;
            r_w1 <= 1'b0;
            r_s2 <= 1'b0;
            r_f2 <= 1'b0;
            r_g2 <= 1'b0;
            r_o3 <= 1'b0;
        end else if (!w_stall) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_x1 <= bus.in_x;
                r_s1 <= bus.in_s;
                r_w1 <= r_tab_w[bus.in_x];
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2 <= r_s1;
                r_f2 <= r_tab_f[w_f_idx];
                r_g2 <= r_tab_g[r_x1];
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_o3 <= r_s2 ? r_g2 : r_f2;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_v3;
    assign bus.out_o     = r_o3;
    assign bus.cfg_busy  = w_busy;

`ifdef LUT_READBACK_EN
    logic w_rdata;
    logic r_rdata;

    always_comb begin
        w_rdata = 1'b0;
        case (bus.cfg_sel)
            2'd0:    w_rdata = r_tab_w[bus.cfg_addr];
            2'd1:    w_rdata = r_tab_f[bus.cfg_addr];
            2'd2:    w_rdata = r_tab_g[bus.cfg_addr];
            default: w_rdata = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 1'b0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign bus.cfg_rdata = r_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_func_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_func_pipe
// Purpose  : Scoreboard bench for lut_func_pipe: directed operands, config
//            writes, backpressure and reset; LUT_READBACK_EN adds readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_func_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    lut_func_pipe_if #(.N_IN(4)) bus ();

    lut_func_pipe #(.N_IN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic       s;
        logic       e;
        int         acyc;
        bit         lat;
    } item_t;

    item_t q[$];
    int    cyc     = 0;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_out   = 0;

    // Default-table results by x: F through W worked out by hand, and G directly.
    logic [15:0] exp_f = 16'h4767;
    logic [15:0] exp_g = 16'h2CE9;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: a transfer is committed at the next rising edge when valid & ready.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    timeout("unexpected_output");
                end else begin
                    it = q.pop_front();
                    check($sformatf("result x=%0d s=%0d", it.x, it.s), int'(bus.out_o), int'(it.e));
                    if (it.lat) check($sformatf("latency x=%0d s=%0d", it.x, it.s), cyc - it.acyc, 3);
                end
            end
        end
    end

    task automatic send(input logic [3:0] sx, input logic ss, input logic se, input bit sl);
        bus.in_valid = 1'b1;
        bus.in_x     = sx;
        bus.in_s     = ss;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{x: sx, s: ss, e: se, acyc: cyc, lat: sl});
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        timeout("send");
    endtask

    task automatic drain();
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid && !bus.cfg_busy) begin
                @(posedge clk); #1;
                return;
            end
        end
        timeout("drain");
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic d);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic e;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_s      = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = 2'd0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_o", int'(bus.out_o), 0);
        check("reset cfg_busy", int'(bus.cfg_busy), 0);
        check("reset in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        // All 32 {s, x} combinations back to back, latency checked on each.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                e = (s == 1) ? exp_g[x] : exp_f[x];
                send(4'(x), 1'(s), e, 1'b1);
            end
        end
        drain();
        check("sweep count", n_out, 32);

        // Backpressure: three items in flight, sink stalled for 5 cycles.
        bus.out_ready = 1'b0;
        n0 = n_out;
        send(4'd3,  1'b0, exp_f[3],  1'b0);
        send(4'd0,  1'b0, exp_f[0],  1'b0);
        send(4'd13, 1'b1, exp_g[13], 1'b0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("stall in_ready", int'(bus.in_ready), 0);
            check("stall out_valid", int'(bus.out_valid), 1);
            check("stall out_o", int'(bus.out_o), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();
        check("stall drain count", n_out - n0, 3);

        // Run-time rewrite of G[0] on an idle pipeline.
        send(4'd0, 1'b1, 1'b1, 1'b0);
        drain();
        cfg_write(2'd2, 4'd0, 1'b0);
        send(4'd0, 1'b1, 1'b0, 1'b0);
        drain();
        cfg_write(2'd2, 4'd0, 1'b1);

        // Write attempted while busy must be dropped.
        bus.out_ready = 1'b0;
        send(4'd5, 1'b1, exp_g[5], 1'b0);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd0;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("busy during write attempt", int'(bus.cfg_busy), 1);
            @(posedge clk); #1;
        end
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        send(4'd0, 1'b0, 1'b1, 1'b0);
        drain();

        // Write and operand in the same cycle: write wins, operand follows.
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'd2;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = 4'd0;
        bus.in_s     = 1'b1;
        @(negedge clk);
        check("collision in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        n0 = n_out;
        send(4'd0, 1'b1, 1'b0, 1'b0);
        drain();
        check("collision count", n_out - n0, 1);

        // Reset with two items in flight and G[0] still rewritten.
        bus.out_ready = 1'b0;
        send(4'd1, 1'b0, exp_f[1], 1'b0);
        send(4'd2, 1'b0, exp_f[2], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset out_valid", int'(bus.out_valid), 1);
        #1 rst = 1'b1;
        q.delete();
        #1;
        check("async reset out_valid", int'(bus.out_valid), 0);
        check("async reset out_o", int'(bus.out_o), 0);
        check("async reset cfg_busy", int'(bus.cfg_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
`ifdef LUT_READBACK_EN
        check("readback reset value", int'(bus.cfg_rdata), 0);
        bus.cfg_sel  = 2'd0;
        bus.cfg_addr = 4'd0;
        @(posedge clk); #1;
        check("readback W[0]", int'(bus.cfg_rdata), 1);
        bus.cfg_sel = 2'd2;
        @(posedge clk); #1;
        check("readback G[0]", int'(bus.cfg_rdata), 1);
        bus.cfg_sel  = 2'd1;
        bus.cfg_addr = 4'd2;
        @(posedge clk); #1;
        check("readback F[2]", int'(bus.cfg_rdata), 1);
        bus.cfg_sel = 2'd3;
        @(posedge clk); #1;
        check("readback sel3", int'(bus.cfg_rdata), 0);
`endif
        send(4'd0, 1'b1, 1'b1, 1'b1);
        send(4'd11, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
